// File: rtl/ifu_pkg.sv
// Shared fetch/branch constants and the redirect target computation, also used by
// the branch-resolve logic in execute.
package ifu_pkg;

   localparam int INST_W   = 32;
   localparam int PC_STEP  = 4;
   localparam int JIDX_W   = 26;
   localparam int IMM_W    = 16;
   localparam int PC_MAX_W = 32;

   // seq is the PC of the instruction after the branch/jump; jump wins when set.
   function automatic logic [PC_MAX_W-1:0] redirect_target(
      input logic                is_jump,
      input logic [PC_MAX_W-1:0] seq,
      input logic [IMM_W-1:0]    imm,
      input logic [JIDX_W-1:0]   jidx
   );
      logic [PC_MAX_W-1:0] boff;
      boff = {{(PC_MAX_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
      if (is_jump)
         return {seq[PC_MAX_W-1:28], jidx, 2'b00};
      return seq + boff;
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Flushable circular FIFO whose head entry is held in a register, so the head is
// visible the cycle after a push into an empty queue.
module ifu_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   start,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           wdata,
   input  logic                   pop,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [AW:0]   count_reg;
   logic [W-1:0]  mem_reg [DEPTH];
   logic [W-1:0]  head_reg;
   logic          do_push, do_pop;

   assign do_pop      = pop && (count_reg != '0);
   assign do_push     = push && ((count_reg != (AW+1)'(DEPTH)) || do_pop);
   assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clock or negedge start) begin
            if (!start)
               mem_reg[gi] <= '0;
            else if (do_push && !flush && (wr_ptr_reg == AW'(gi)))
               mem_reg[gi] <= wdata;
         end
      end
   endgenerate

   always_ff @(posedge clock or negedge start) begin
      if (!start) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
         // Bypass the write when the pushed entry becomes the new head.
         head_reg   <= (do_push && (wr_ptr_reg == rd_ptr_next)) ? wdata : mem_reg[rd_ptr_next];
      end
   end

   assign rdata = head_reg;
   assign count = count_reg;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with prefetch queue, in-order response tagging and redirect
// flush. Define IFU_PERF_EN to add saturating perf_fetch/perf_redirect/perf_stall counters.
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clock,
   input  logic                start,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_gnt,
   input  logic                imem_rvalid,
   input  logic [INST_W-1:0]   imem_rdata,
   output logic                inst_valid,
   output logic [INST_W-1:0]   inst_data,
   output logic [ADDR_W-1:0]   inst_pc,
   input  logic                inst_ready,
   input  logic                branch,
   input  logic                zero,
   input  logic                jump,
   input  logic [ADDR_W-1:0]   redir_pc,
   input  logic [IMM_W-1:0]    imm16,
   input  logic [JIDX_W-1:0]   jidx26
`ifdef IFU_PERF_EN
   ,
   output logic [31:0]         perf_fetch,
   output logic [31:0]         perf_redirect,
   output logic [31:0]         perf_stall
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int QW = INST_W + ADDR_W;

   logic [ADDR_W-1:0]   pc_reg;
   logic                run_reg;
   logic [CW-1:0]       inflight_reg, inflight_next;
   logic [CW-1:0]       drop_reg, drop_next;
   logic [CW-1:0]       q_count, t_count;
   logic [CW:0]         occupancy;
   logic [ADDR_W-1:0]   seq, target, tag_head;
   logic [PC_MAX_W-1:0] target_wide;
   logic [QW-1:0]       q_head;
   logic                taken, issue, rsp, rsp_keep, pop;

   assign taken       = jump | (branch & zero);
   assign seq         = redir_pc + ADDR_W'(PC_STEP);
   assign target_wide = redirect_target(jump, PC_MAX_W'(seq), imm16, jidx26);
   assign target      = target_wide[ADDR_W-1:0];

   // Credits: queued entries plus outstanding requests never exceed DEPTH.
   assign occupancy = {1'b0, q_count} + {1'b0, inflight_reg};
   assign imem_req  = run_reg && !taken && (occupancy < (CW+1)'(DEPTH));
   assign imem_addr = pc_reg;
   assign issue     = imem_req && imem_gnt;
   assign rsp       = imem_rvalid && (inflight_reg != '0);
   assign rsp_keep  = rsp && (drop_reg == '0);
   assign pop       = inst_valid && inst_ready;

   assign inst_valid = (q_count != '0);
   assign inst_data  = q_head[QW-1:ADDR_W];
   assign inst_pc    = q_head[ADDR_W-1:0];

   assign inflight_next = inflight_reg + CW'(issue) - CW'(rsp);

   // Every request still outstanding after a redirect is stale.
   always_comb begin
      drop_next = drop_reg;
      if (taken)
         drop_next = inflight_next;
      else if (rsp && (drop_reg != '0))
         drop_next = drop_reg - CW'(1);
   end

   always_ff @(posedge clock or negedge start) begin
      if (!start) begin
         pc_reg       <= RESET_PC;
         run_reg      <= 1'b0;
         inflight_reg <= '0;
         drop_reg     <= '0;
      end else begin
         run_reg      <= 1'b1;
         inflight_reg <= inflight_next;
         drop_reg     <= drop_next;
         if (taken)
            pc_reg <= target;
         else if (issue)
            pc_reg <= pc_reg + ADDR_W'(PC_STEP);
      end
   end

   ifu_fifo #(.W(QW), .DEPTH(DEPTH)) u_inst_q (
      .clock (clock),
      .start (start),
      .flush (taken),
      .push  (rsp_keep && !taken),
      .wdata ({imem_rdata, tag_head}),
      .pop   (pop),
      .rdata (q_head),
      .count (q_count)
   );

   ifu_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
      .clock (clock),
      .start (start),
      .flush (taken),
      .push  (issue),
      .wdata (pc_reg),
      .pop   (rsp_keep),
      .rdata (tag_head),
      .count (t_count)
   );

   rvalid_idle_a: assert property (@(posedge clock) disable iff (!start)
      !(imem_rvalid && (inflight_reg == '0)));
   tag_present_a: assert property (@(posedge clock) disable iff (!start)
      rsp_keep |-> (t_count != '0));

`ifdef IFU_PERF_EN
   logic [31:0] perf_fetch_reg, perf_redirect_reg, perf_stall_reg;

   always_ff @(posedge clock or negedge start) begin
      if (!start) begin
         perf_fetch_reg    <= '0;
         perf_redirect_reg <= '0;
         perf_stall_reg    <= '0;
      end else begin
         if (pop && (perf_fetch_reg != '1))
            perf_fetch_reg <= perf_fetch_reg + 32'd1;
         if (taken && (perf_redirect_reg != '1))
            perf_redirect_reg <= perf_redirect_reg + 32'd1;
         if (inst_ready && !inst_valid && (perf_stall_reg != '1))
            perf_stall_reg <= perf_stall_reg + 32'd1;
      end
   end

   assign perf_fetch    = perf_fetch_reg;
   assign perf_redirect = perf_redirect_reg;
   assign perf_stall    = perf_stall_reg;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: redirect-target vector table plus streaming,
// back-pressure, flush and async-reset sequences against a 1-cycle memory model.
module tb_ifu_prefetch;

   logic        clock = 1'b0;
   logic        start;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        branch, zero, jump;
   logic [31:0] redir_pc;
   logic [15:0] imm16;
   logic [25:0] jidx26;
`ifdef IFU_PERF_EN
   logic [31:0] perf_fetch, perf_redirect, perf_stall;
`endif

   ifu_prefetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clock       (clock),
      .start       (start),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_data   (inst_data),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready),
      .branch      (branch),
      .zero        (zero),
      .jump        (jump),
      .redir_pc    (redir_pc),
      .imm16       (imm16),
      .jidx26      (jidx26)
`ifdef IFU_PERF_EN
      ,
      .perf_fetch    (perf_fetch),
      .perf_redirect (perf_redirect),
      .perf_stall    (perf_stall)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        br, z, jp;
      logic [31:0] rpc;
      logic [15:0] imm;
      logic [25:0] jidx;
      logic        exp_req;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t        vt [9];
   int          total = 0;
   int          bad = 0;
   int          cyc, issues, first_valid;
   logic        req_seen;
   bit          rsp_en;
   logic [31:0] pend [$];
   logic [31:0] got_pc [$];
   logic [31:0] got_data [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic clear_redir();
      branch = 0; zero = 0; jump = 0; redir_pc = '0; imm16 = '0; jidx26 = '0;
   endtask

   // Called right after a negedge with this cycle's inputs set; returns at the next negedge.
   task automatic run_cycle();
      #1;
      req_seen = imem_req;
      if (imem_req && imem_gnt) begin
         pend.push_back(imem_addr);
         issues++;
      end
      if (inst_valid === 1'b1 && first_valid < 0)
         first_valid = cyc;
      if (inst_valid && inst_ready) begin
         got_pc.push_back(inst_pc);
         got_data.push_back(inst_data);
         $display("pop cyc=%0d pc=%h data=%h", cyc, inst_pc, inst_data);
      end
      @(negedge clock);
      cyc++;
      if (rsp_en && pend.size() > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = ~pend.pop_front();
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
   endtask

   task automatic do_reset();
      start = 1'b0;
      rsp_en = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; inst_ready = 0;
      clear_redir();
      pend.delete(); got_pc.delete(); got_data.delete();
      repeat (2) @(negedge clock);
      start = 1'b1;
      cyc = 0; issues = 0; first_valid = -1;
   endtask

   task automatic collect(input int n, input int max_c);
      int k = 0;
      while (got_pc.size() < n && k < max_c) begin
         run_cycle();
         k++;
      end
   endtask

   task automatic check_seq(input string name, input int n, input logic [31:0] base);
      logic [31:0] e;
      chk({name, "_count"}, 64'(got_pc.size()), 64'(n));
      for (int i = 0; i < n && i < got_pc.size(); i++) begin
         e = base + 32'(4 * i);
         chk($sformatf("%s_%0d", name, i), {got_pc[i], got_data[i]}, {e, ~e});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      //             br z  jp rpc            imm       jidx          req addr
      vt[0] = '{1, 1, 0, 32'h0000_0010, 16'hFFFE, 26'h0,        0, 32'h0000_000C};
      vt[1] = '{1, 0, 0, 32'h0000_0100, 16'h0005, 26'h0,        1, 32'h0000_000C};
      vt[2] = '{0, 0, 1, 32'hF000_0000, 16'h0000, 26'h3FF_FFFF, 0, 32'hFFFF_FFFC};
      vt[3] = '{1, 1, 0, 32'h0000_1000, 16'h0010, 26'h0,        0, 32'h0000_1044};
      vt[4] = '{1, 1, 1, 32'h2000_0000, 16'h0001, 26'h000_0123, 0, 32'h2000_048C};
      vt[5] = '{1, 1, 0, 32'hFFFF_FFFC, 16'h0000, 26'h0,        0, 32'h0000_0000};
      vt[6] = '{1, 1, 0, 32'h0000_0000, 16'h8000, 26'h0,        0, 32'hFFFE_0004};
      vt[7] = '{0, 0, 1, 32'h0FFF_FFFC, 16'h0000, 26'h000_0001, 0, 32'h1000_0004};
      vt[8] = '{0, 1, 0, 32'h0000_0200, 16'h0003, 26'h0,        1, 32'h1000_0004};

      start = 1'b0;
      rsp_en = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; inst_ready = 0;
      clear_redir();
      #1;
      chk("rst_req",   64'(imem_req),   64'(0));
      chk("rst_valid", 64'(inst_valid), 64'(0));
      chk("rst_data",  64'(inst_data),  64'(0));
      chk("rst_pc",    64'(inst_pc),    64'(0));
      chk("rst_addr",  64'(imem_addr),  64'(0));
      @(negedge clock);

      // Redirect target table: no grants, so a non-taken vector leaves the PC alone.
      do_reset();
      run_cycle();
      for (int i = 0; i < 9; i++) begin
         branch = vt[i].br; zero = vt[i].z; jump = vt[i].jp;
         redir_pc = vt[i].rpc; imm16 = vt[i].imm; jidx26 = vt[i].jidx;
         run_cycle();
         clear_redir();
         $display("vec %0d req=%0d addr=%h", i, req_seen, imem_addr);
         chk($sformatf("vec%0d_req", i),  64'(req_seen),  64'(vt[i].exp_req));
         chk($sformatf("vec%0d_addr", i), 64'(imem_addr), 64'(vt[i].exp_addr));
      end

      // Free-running stream.
      do_reset();
      imem_gnt = 1; rsp_en = 1; inst_ready = 1;
      collect(8, 40);
      chk("first_valid_ge3", 64'(first_valid >= 3), 64'(1));
      check_seq("stream", 8, 32'h0);

      // Decode stalled: exactly DEPTH requests, then in-order drain.
      do_reset();
      imem_gnt = 1; rsp_en = 1; inst_ready = 0;
      repeat (20) run_cycle();
      chk("stall_issues", 64'(issues), 64'(4));
      chk("stall_req", 64'(imem_req), 64'(0));
      chk("stall_head", {31'b0, inst_valid, inst_pc}, {31'b0, 1'b1, 32'h0});
      inst_ready = 1;
      collect(8, 40);
      check_seq("drain", 8, 32'h0);

      // Taken branch with three requests outstanding, then a non-taken branch.
      do_reset();
      imem_gnt = 1; rsp_en = 0; inst_ready = 1;
      for (int k = 0; k < 20 && issues < 3; k++) run_cycle();
      chk("br_inflight", 64'(issues), 64'(3));
      imem_gnt = 0;
      branch = 1; zero = 1; redir_pc = 32'h10; imm16 = 16'hFFFE;
      run_cycle();
      clear_redir();
      chk("br_req", 64'(req_seen), 64'(0));
      chk("br_addr", 64'(imem_addr), 64'(32'h0C));
      got_pc.delete(); got_data.delete();
      imem_gnt = 1; rsp_en = 1;
      run_cycle();
      branch = 1; zero = 0; redir_pc = 32'h40; imm16 = 16'h0007;
      run_cycle();
      clear_redir();
      collect(6, 40);
      check_seq("br_taken", 6, 32'h0C);

      // Jump in the same cycle as a response; target wraps to zero afterwards.
      do_reset();
      imem_gnt = 1; rsp_en = 1; inst_ready = 1;
      for (int k = 0; k < 20 && !(issues >= 3 && imem_rvalid); k++) run_cycle();
      chk("jmp_rvalid", 64'(imem_rvalid), 64'(1));
      jump = 1; redir_pc = 32'hF000_0000; jidx26 = 26'h3FF_FFFF;
      run_cycle();
      clear_redir();
      got_pc.delete(); got_data.delete();
      chk("jmp_addr", 64'(imem_addr), 64'(32'hFFFF_FFFC));
      collect(3, 30);
      check_seq("jump", 3, 32'hFFFF_FFFC);

      // Asynchronous reset with the queue full.
      do_reset();
      imem_gnt = 1; rsp_en = 1; inst_ready = 0;
      repeat (12) run_cycle();
      chk("full_before_rst", {31'b0, inst_valid, inst_pc}, {31'b0, 1'b1, 32'h0});
      #2 start = 1'b0;
      #1;
      chk("arst_valid", 64'(inst_valid), 64'(0));
      chk("arst_req",   64'(imem_req),   64'(0));
      chk("arst_pc",    64'(inst_pc),    64'(0));
      chk("arst_data",  64'(inst_data),  64'(0));
      @(negedge clock);
      @(negedge clock);
      pend.delete(); got_pc.delete(); got_data.delete();
      imem_rvalid = 0;
      start = 1'b1;
      cyc = 0; issues = 0; first_valid = -1;
      inst_ready = 1;
      collect(2, 30);
      check_seq("after_rst", 2, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised instruction fetch unit for the multi-cycle/pipelined core, succeeding the single-cycle fetch path.
- Holds the PC and issues word-aligned fetches to an instruction memory with variable latency, using a req/gnt/rvalid handshake.
- Buffers returned instructions in a DEPTH-entry prefetch queue and hands them to decode over a valid/ready interface.
- Computes branch and jump targets internally and flushes on redirect.

Parameters:
ADDR_W, 32, PC/address width in bits (bits [1:0] always 0)
DEPTH, 4, prefetch queue entries; power of 2, minimum 2
RESET_PC, 32'h0000_0000, PC loaded while start is low

Ports:
clock  in  1  sole clock, rising edge
start  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address (word-aligned)
imem_gnt  in  1  request accepted this cycle (req&&gnt = issue)
imem_rvalid  in  1  response data valid; responses return in issue order
imem_rdata  in  32  instruction word
inst_valid  out  1  queue head valid to decode
inst_data  out  32  queue head instruction
inst_pc  out  ADDR_W  PC of queue head
inst_ready  in  1  decode consumes head when valid&&ready
branch  in  1  branch instruction resolving this cycle
zero  in  1  ALU zero flag for that branch
jump  in  1  jump instruction resolving this cycle
redir_pc  in  ADDR_W  PC of the resolving branch/jump
imm16  in  16  branch offset (words, signed)
jidx26  in  26  jump index

Behaviour:
- Reset (start low, async): fetch PC = RESET_PC; queue empty; in-flight count = 0; drop count = 0; imem_req = 0; inst_valid = 0; inst_data/inst_pc = 0.
- Redirect: taken = jump | (branch & zero). Jump has priority over branch.
  - seq = redir_pc + 4.
  - Branch target = seq + (sext(imm16) << 2), mod 2^ADDR_W.
  - Jump target = {seq[ADDR_W-1:28], jidx26, 2'b00}.
- Issue rule: imem_req = 1 when (queue occupancy + in-flight) < DEPTH and no redirect this cycle. On req&&gnt, the PC advances by 4 and in-flight increments. The PC wraps at 2^ADDR_W.
- Response:
  - imem_rvalid with drop count > 0: discard and decrement drop count.
  - Otherwise: push {rdata, pc-tag} into the queue. The pc-tag comes from an issue-order PC tag FIFO.
  - In-flight decrements either way.
- Decode side:
  - inst_valid = queue not empty; inst_data/inst_pc are registered outputs of the head entry.
  - Pop on valid&&ready.
  - Push into an empty queue is visible on the next cycle (1-cycle minimum fill latency). Simultaneous push and pop at full is legal.
- Redirect cycle:
  - Queue flushed; PC = target on the next edge.
  - drop count += in-flight entries whose responses have not yet returned, counting any issue granted this cycle and excluding any response arriving this cycle.
  - Any rvalid in the redirect cycle is discarded.
  - imem_req = 0 in the redirect cycle; issue resumes the following cycle from the target.
  - A pop in the redirect cycle still completes (decode saw it).
- Back-to-back redirects: the later one wins; drop counts accumulate.
- Full: no new requests. Total occupancy plus in-flight never exceeds DEPTH, so a response never meets a full queue.
- imem_gnt without imem_req is ignored. imem_rvalid with in-flight == 0 is a protocol error: ignored, and an assertion fires in simulation.
- start asserted mid-operation: all state clears immediately. Responses to pre-reset requests must not arrive after release; that is a system guarantee.

Optional Feature:
IFU_PERF_EN
- Defined: adds outputs perf_fetch (32), perf_redirect (32) and perf_stall (32), reset to 0, saturating.
  - perf_fetch counts pops.
  - perf_redirect counts taken redirects.
  - perf_stall counts cycles with inst_ready=1 and inst_valid=0.
- Undefined: these ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package ifu_pkg: INST_W=32, PC_STEP=4, JIDX_W=26, IMM_W=16, and the target-computation function (branch/jump target). It is shared with the branch-resolve logic in execute.
- Sub-module ifu_fifo (parametrised width/depth, flush, push/pop, count). It is instantiated twice:
  - once for the instruction queue;
  - once as the in-flight PC tag FIFO.

Test Plan:
- Reset, DEPTH=4, imem gnt every cycle, 1-cycle rvalid, inst_ready=1 → inst_pc sequence 0x0,0x4,0x8,…; first inst_valid no earlier than cycle 3 after start rises.
- inst_ready=0 for 20 cycles → exactly 4 issues; imem_req=0 afterwards; queue holds PCs 0x0–0xC; release ready → in-order drain, no loss.
- Branch, 3 requests in flight: branch=1, zero=1, redir_pc=0x10, imm16=0xFFFE → next fetch 0x0C; the 3 stale responses are dropped; first delivered inst_pc=0x0C.
- Branch not taken: branch=1, zero=0 → no flush; sequence continues.
- Jump, same cycle as rvalid: jump=1, redir_pc=0xF000_0000, jidx26=0x3FFFFFF → target 0xFFFF_FFFC; that rvalid is discarded; the next PC wraps to 0x0000_0000.
- Async reset mid-stream with queue full → outputs cleared with no clock edge; after release, fetch restarts at RESET_PC.
